// File: rtl/cs_decoder_seq.sv
// Registered chip-select decoder with a per-target wait-state table.
// One access is active at a time; READY marks its final cycle, ERR flags an out-of-range select.
module cs_decoder_seq #(
  parameter int SEL_W        = 3,
  parameter int N_OUT        = 8,
  parameter int WAIT_W       = 4,
  parameter int DEFAULT_WAIT = 0
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              EN,
  input  logic [SEL_W-1:0]  SEL,
  input  logic              ABORT,
  input  logic              CFG_WE,
  input  logic [SEL_W-1:0]  CFG_SEL,
  input  logic [WAIT_W-1:0] CFG_WAIT,
  output logic [N_OUT-1:0]  OUT,
  output logic              BUSY,
  output logic              READY,
  output logic              ERR
);

  localparam int              DEPTH   = 2**SEL_W;
  localparam logic [SEL_W:0]  N_OUT_W = (SEL_W+1)'(N_OUT);
  localparam logic [WAIT_W-1:0] DEF_W = WAIT_W'(DEFAULT_WAIT);
  localparam logic [WAIT_W-1:0] ONE_W = WAIT_W'(1);

  typedef enum logic {IDLE, ACTIVE} state_e;

  state_e            state_q, state_d;
  logic [N_OUT-1:0]  out_q, out_d;
  logic [WAIT_W-1:0] cnt_q, cnt_d;
  logic              ready_q, ready_d;
  logic              err_q, err_d;
  logic [WAIT_W-1:0] table_q [DEPTH];
  logic [WAIT_W-1:0] table_d [DEPTH];

  logic              busy;
  logic              accept;
  logic              sel_ok;
  logic              cfg_ok;
  logic [WAIT_W-1:0] wait_sel;

  assign busy = (state_q == ACTIVE);

  always_comb begin
    accept   = EN & ~ABORT & (~busy | ready_q);
    sel_ok   = {1'b0, SEL} < N_OUT_W;
    cfg_ok   = {1'b0, CFG_SEL} < N_OUT_W;
    // Table is read before this cycle's write lands, so a same-index write
    // alongside an accept only affects later requests.
    wait_sel = table_q[SEL];

    state_d = IDLE;
    out_d   = '0;
    cnt_d   = '0;
    ready_d = 1'b0;
    err_d   = 1'b0;
    table_d = table_q;

    if (accept) begin
      if (sel_ok) begin
        state_d = ACTIVE;
        out_d   = {{(N_OUT-1){1'b0}}, 1'b1} << SEL;
        cnt_d   = wait_sel;
        ready_d = (wait_sel == '0);
      end else begin
        err_d = 1'b1;
      end
    end else if (busy && !ready_q && !ABORT) begin
      state_d = ACTIVE;
      out_d   = out_q;
      cnt_d   = cnt_q - ONE_W;
      ready_d = (cnt_q == ONE_W);
    end

    if (CFG_WE && cfg_ok) begin
      table_d[CFG_SEL] = CFG_WAIT;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      out_q   <= '0;
      cnt_q   <= '0;
      ready_q <= 1'b0;
      err_q   <= 1'b0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        table_q[i] <= DEF_W;
      end
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      cnt_q   <= cnt_d;
      ready_q <= ready_d;
      err_q   <= err_d;
      table_q <= table_d;
    end
  end

  assign OUT   = out_q;
  assign BUSY  = busy;
  assign READY = ready_q;
  assign ERR   = err_q;

endmodule

// File: tb/tb_cs_decoder_seq.sv
// Scoreboarded bench for cs_decoder_seq (N_OUT=6): a transaction-level model predicts
// each cycle's outputs, a separate monitor compares them against the DUT.
module tb_cs_decoder_seq;

  localparam int N = 6;

  logic         CLK = 1'b0;
  logic         RST = 1'b1;
  logic         EN = 1'b0;
  logic [2:0]   SEL = '0;
  logic         ABORT = 1'b0;
  logic         CFG_WE = 1'b0;
  logic [2:0]   CFG_SEL = '0;
  logic [3:0]   CFG_WAIT = '0;
  logic [N-1:0] OUT;
  logic         BUSY, READY, ERR;

  cs_decoder_seq #(.SEL_W(3), .N_OUT(N), .WAIT_W(4), .DEFAULT_WAIT(0)) dut (
    .CLK(CLK), .RST(RST), .EN(EN), .SEL(SEL), .ABORT(ABORT),
    .CFG_WE(CFG_WE), .CFG_SEL(CFG_SEL), .CFG_WAIT(CFG_WAIT),
    .OUT(OUT), .BUSY(BUSY), .READY(READY), .ERR(ERR)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [N-1:0] out;
    logic         busy;
    logic         ready;
    logic         err;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;

  // Model: current target (-1 when idle), cycles left in the access including this one.
  int m_tgt = -1;
  int m_left = 0;
  bit m_err = 0;
  int m_tab [N];

  task automatic cyc(input bit rst, input bit en, input int sel, input bit ab,
                     input bit we, input int cs, input int cw);
    bit   rdy, bsy, acc;
    exp_t e;
    @(negedge CLK);
    RST = rst; EN = en; SEL = sel[2:0]; ABORT = ab;
    CFG_WE = we; CFG_SEL = cs[2:0]; CFG_WAIT = cw[3:0];
    if (rst) begin
      m_tgt = -1; m_left = 0; m_err = 0;
      for (int i = 0; i < N; i++) m_tab[i] = 0;
    end else begin
      bsy = (m_tgt >= 0);
      rdy = bsy && (m_left == 1);
      acc = en && !ab && (!bsy || rdy);
      m_err = 0;
      if (acc) begin
        if (sel < N) begin
          m_tgt = sel; m_left = m_tab[sel] + 1;
        end else begin
          m_tgt = -1; m_err = 1;
        end
      end else if (bsy) begin
        if (rdy || ab) m_tgt = -1;
        else m_left = m_left - 1;
      end
      if (we && cs < N) m_tab[cs] = cw;
    end
    e.out   = (m_tgt >= 0) ? N'(1 << m_tgt) : '0;
    e.busy  = (m_tgt >= 0);
    e.ready = (m_tgt >= 0) && (m_left == 1);
    e.err   = m_err;
    q.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic cfg(input int cs, input int cw);
    cyc(0, 0, 0, 0, 1, cs, cw);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge CLK);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        total++;
        if (OUT !== e.out || BUSY !== e.busy || READY !== e.ready || ERR !== e.err) begin
          bad++;
          $display("FAIL cycle_outputs t=%0t got out=%h busy=%b ready=%b err=%b exp out=%h busy=%b ready=%b err=%b",
                   $time, OUT, BUSY, READY, ERR, e.out, e.busy, e.ready, e.err);
        end
      end
    end
  end

  initial begin : stim
    for (int i = 0; i < N; i++) m_tab[i] = 0;
    cyc(1, 0, 0, 0, 0, 0, 0);
    cyc(1, 1, 3, 0, 1, 2, 9);
    // T1: default wait 0
    cyc(0, 1, 5, 0, 0, 0, 0);
    idle(2);
    // T2: three wait states
    cfg(2, 3);
    cyc(0, 1, 2, 0, 0, 0, 0);
    idle(5);
    // T3: back-to-back accept in the READY cycle
    cfg(1, 1);
    cyc(0, 1, 1, 0, 0, 0, 0);
    idle(1);
    cyc(0, 1, 6 - 1, 0, 0, 0, 0);
    idle(2);
    // T4: out-of-range select, then a dropped request while busy
    cyc(0, 1, 7, 0, 0, 0, 0);
    cyc(0, 1, 6, 0, 0, 0, 0);
    idle(1);
    cyc(0, 1, 2, 0, 0, 0, 0);
    cyc(0, 1, 4, 0, 0, 0, 0);
    idle(4);
    // T5: abort mid-access, then abort during READY
    cfg(3, 5);
    cyc(0, 1, 3, 0, 0, 0, 0);
    cyc(0, 0, 0, 1, 0, 0, 0);
    idle(2);
    cyc(0, 1, 0, 0, 0, 0, 0);
    cyc(0, 1, 1, 1, 0, 0, 0);
    idle(2);
    // Same-cycle write and accept to one index uses the old wait
    cyc(0, 1, 2, 0, 1, 2, 7);
    idle(10);
    // T6: reset mid-access with a write to the active index
    cfg(4, 4);
    cyc(0, 1, 4, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 1, 4, 9);
    idle(1);
    cyc(1, 0, 0, 0, 0, 0, 0);
    cyc(0, 1, 4, 0, 0, 0, 0);
    idle(2);
    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      cyc($urandom_range(0, 149) == 0, $urandom_range(0, 1) == 1, $urandom_range(0, 7),
          $urandom_range(0, 7) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 7),
          $urandom_range(0, 15));
    end
    idle(2);
    @(posedge CLK);
    #2;
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain got=%0d pending exp=0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
